// File: rtl/immediate_pipe.sv
// immediate_pipe: extracts and extends the immediate field of a RISC-V instruction word.
// The block has a valid/ready handshake on each side. It holds one output register and one
// skid entry, so the block can accept one instruction per cycle. Results leave in the order
// the instructions were accepted.
//
// Optional feature: define IMMEDIATE_PIPE_CSR_EN to decode the CSR zimm immediate
// (opcode 1110011). When the macro is undefined, that opcode decodes as illegal.
//
// Ports:
//   clk         - single clock; all state updates on its rising edge
//   rst         - synchronous active-high reset
//   in_valid    - an instruction is present on the instruction input
//   in_ready    - the block can accept an instruction (low while the skid is full or during rst)
//   instruction - raw RV instruction word
//   out_valid   - a result is present
//   out_ready   - the consumer accepts the result
//   immediate   - extended immediate (signed, IMMSIZE bits)
//   imm_fmt     - 0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 illegal
//   imm_illegal - high when imm_fmt == 7

module immediate_pipe #(
    parameter int unsigned INSTRSIZE = 32,
    parameter int unsigned IMMSIZE   = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTRSIZE-1:0]       instruction,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [IMMSIZE-1:0]  immediate,
    output logic [2:0]                 imm_fmt,
    output logic                       imm_illegal
);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMMEDIATE_PIPE_CSR_EN
    localparam logic [2:0] FMT_CSR  = 3'd6;
`endif
    localparam logic [2:0] FMT_ILL  = 3'd7;

    // Sign-extend a 32-bit value from bit 31 to the full immediate width.
    function automatic logic signed [IMMSIZE-1:0] sext32(input logic [31:0] v);
        return IMMSIZE'($signed(v));
    endfunction

    logic signed [IMMSIZE-1:0] w_dec_imm;
    logic [2:0]                w_dec_fmt;
    logic                      w_accept;
    logic                      w_drain;

    logic                      r_out_valid;
    logic signed [IMMSIZE-1:0] r_out_imm;
    logic [2:0]                r_out_fmt;
    logic                      r_skid_valid;
    logic signed [IMMSIZE-1:0] r_skid_imm;
    logic [2:0]                r_skid_fmt;

    // Combinational decode of the incoming word.
    always_comb begin
        w_dec_fmt = FMT_ILL;
        w_dec_imm = '0;
        if (instruction[1:0] == 2'b11) begin
            case (instruction[6:0])
                7'b0110011, 7'b0111011: begin
                    w_dec_fmt = FMT_NONE;
                end
                7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111: begin
                    w_dec_fmt = FMT_I;
                    w_dec_imm = sext32({{20{instruction[31]}}, instruction[31:20]});
                end
                7'b0100011: begin
                    w_dec_fmt = FMT_S;
                    w_dec_imm = sext32({{20{instruction[31]}}, instruction[31:25],
                                        instruction[11:7]});
                end
                7'b1100011: begin
                    w_dec_fmt = FMT_B;
                    w_dec_imm = sext32({{19{instruction[31]}}, instruction[31], instruction[7],
                                        instruction[30:25], instruction[11:8], 1'b0});
                end
                7'b0110111, 7'b0010111: begin
                    w_dec_fmt = FMT_U;
                    w_dec_imm = sext32({instruction[31:12], 12'b0});
                end
                7'b1101111: begin
                    w_dec_fmt = FMT_J;
                    w_dec_imm = sext32({{11{instruction[31]}}, instruction[31],
                                        instruction[19:12], instruction[20],
                                        instruction[30:21], 1'b0});
                end
`ifdef IMMEDIATE_PIPE_CSR_EN
                7'b1110011: begin
                    // funct3[2] selects the immediate CSR forms; zimm is zero-extended.
                    if (instruction[14]) begin
                        w_dec_fmt = FMT_CSR;
                        w_dec_imm = IMMSIZE'(instruction[19:15]);
                    end else begin
                        w_dec_fmt = FMT_NONE;
                    end
                end
`endif
                default: begin
                    w_dec_fmt = FMT_ILL;
                end
            endcase
        end
    end

    assign in_ready = !r_skid_valid && !rst;
    assign w_accept = in_valid && in_ready;
    assign w_drain  = r_out_valid && out_ready;

    // The skid can only be occupied while the output register is full and stalled.
    // It refills the output register when the output drains, so results keep their order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_fmt    <= FMT_NONE;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_fmt   <= FMT_NONE;
        end else if (w_drain) begin
            if (r_skid_valid) begin
                r_out_imm    <= r_skid_imm;
                r_out_fmt    <= r_skid_fmt;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_out_imm    <= w_dec_imm;
                r_out_fmt    <= w_dec_fmt;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_out_valid) begin
                r_skid_valid <= 1'b1;
                r_skid_imm   <= w_dec_imm;
                r_skid_fmt   <= w_dec_fmt;
            end else begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= w_dec_imm;
                r_out_fmt    <= w_dec_fmt;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign immediate   = r_out_imm;
    assign imm_fmt     = r_out_fmt;
    assign imm_illegal = (r_out_fmt == FMT_ILL);

endmodule
